// File: rtl/imem_stream_loader_if.sv
// Byte-stream receive handshake plus IMem single-cycle write port.
// The loader drives the master side; the stream source and IMem sit on the slave side.
interface imem_stream_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Assembles a length-prefixed little-endian byte stream into sequential 32-bit IMem writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing byte that makes the stream XOR to zero.
module imem_stream_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    imem_stream_loader_if.master bus,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W:0]      words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_LAST_WR,
        ST_DONE,
        ST_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        ST_CHECK
`endif
    } state_t;

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] word_count;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    logic        accept;
    logic [15:0] len_value;
    logic        last_word;
    logic        start_ok;

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign len_value = {bus.rx_data, len_lo};
    assign last_word = (32'(words_loaded) + 32'd1) == 32'(word_count);
    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every accepted byte, length and checksum included.
    logic [7:0] csum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (start_ok) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ bus.rx_data;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cpu_reset      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= '0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            len_lo         <= '0;
            word_count     <= '0;
            byte_idx       <= '0;
            word_buf       <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state        <= ST_LEN_LO;
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        bus.rx_ready <= 1'b1;
                        byte_idx     <= '0;
                        word_buf     <= '0;
                    end
                end

                ST_LEN_LO: begin
                    if (accept) begin
                        len_lo <= bus.rx_data;
                        state  <= ST_LEN_HI;
                    end
                end

                ST_LEN_HI: begin
                    if (accept) begin
                        word_count <= len_value;
                        if ({1'b0, len_value} > DEPTH_LIM) begin
                            state        <= ST_ERROR;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                        end else if (len_value == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= ST_CHECK;
`else
                            state        <= ST_DONE;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            cpu_reset    <= 1'b0;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                // The fourth byte of each word launches the write on the following cycle.
                ST_DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            default: begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= words_loaded[ADDR_W-1:0];
                                bus.imem_wdata <= {bus.rx_data, word_buf};
                                words_loaded   <= words_loaded + (ADDR_W + 1)'(1);
                                if (last_word) begin
                                    state        <= ST_LAST_WR;
                                    bus.rx_ready <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                ST_LAST_WR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state        <= ST_CHECK;
                    bus.rx_ready <= 1'b1;
`else
                    state     <= ST_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    cpu_reset <= 1'b0;
`endif
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        if ((csum ^ bus.rx_data) == 8'h00) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state        <= ST_IDLE;
                    bus.rx_ready <= 1'b0;
                    busy         <= 1'b0;
                    cpu_reset    <= 1'b1;
                end
            endcase
        end
    end

endmodule
